// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the SRAM/serial bus arbiter: FSM states,
// IO word offsets and idle levels of the active-low SRAM strobes.
package sram_bus_arbiter_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_ACCESS  = 3'd2;
    localparam logic [2:0] ST_RECOVER = 3'd3;
    localparam logic [2:0] ST_IO      = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam logic IO_OFF_DATA   = 1'b0;
    localparam logic IO_OFF_STATUS = 1'b1;

    localparam logic STROBE_IDLE = 1'b1;

    localparam logic [1:0] STARVE_LIMIT = 2'd2;

endpackage

// File: rtl/bus_grant_arbiter.sv
// Two-way grant: data port B has priority, but after two back-to-back
// B grants with fetch port A waiting, A is granted next.
module bus_grant_arbiter
    import sram_bus_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic a_req,
    input  logic b_req,
    output logic grant_a,
    output logic grant_b
);

    logic [1:0] b_run;

    assign grant_a = idle & a_req & (~b_req | (b_run == STARVE_LIMIT));
    assign grant_b = idle & b_req & ~grant_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            b_run <= 2'd0;
        end else if (grant_a || !a_req) begin
            b_run <= 2'd0;
        end else if (grant_b) begin
            b_run <= b_run + 2'd1;
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one asynchronous SRAM between CPU fetch (A) and data (B) ports
// and decodes a small window of memory-mapped serial channels.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int PHYS_ADDR_W = 18,
    parameter int WAIT_STATES = 1,
    parameter int NUM_IO      = 2,
    parameter logic [ADDR_W-1:0] IO_BASE = 16'hBF00
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_req,
    input  logic [ADDR_W-1:0]      a_addr,
    output logic [DATA_W-1:0]      a_rdata,
    output logic                   a_ack,
    input  logic                   b_req,
    input  logic                   b_we,
    input  logic [ADDR_W-1:0]      b_addr,
    input  logic [DATA_W-1:0]      b_wdata,
    output logic [DATA_W-1:0]      b_rdata,
    output logic                   b_ack,
    output logic                   stall,
    output logic [PHYS_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]      mem_dout,
    output logic                   mem_drive,
    input  logic [DATA_W-1:0]      mem_din,
    output logic                   mem_en_n,
    output logic                   mem_oe_n,
    output logic                   mem_we_n,
    output logic [NUM_IO-1:0]      io_sel,
    output logic                   io_rd,
    output logic                   io_wr,
    output logic [7:0]             io_wdata,
    input  logic [8*NUM_IO-1:0]    io_rdata,
    input  logic [2*NUM_IO-1:0]    io_status
);

    localparam int CW   = $clog2(WAIT_STATES + 1);
    localparam int CH_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;

    logic [2:0]        state;
    logic              owner_b;
    logic              lat_we;
    logic              lat_odd;
    logic [CH_W-1:0]   lat_ch;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [CW-1:0]     wcnt;

    logic              grant_a;
    logic              grant_b;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W:0]   off;
    logic              in_win;
    logic              sram_act;
    logic [7:0]        io_byte;
    logic [1:0]        io_st;
    logic [DATA_W-1:0] io_val;

    bus_grant_arbiter u_grant (
        .clk     (clk),
        .rst     (rst),
        .idle    (state == ST_IDLE),
        .a_req   (a_req),
        .b_req   (b_req),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    assign sel_addr = grant_b ? b_addr : a_addr;
    assign off      = {1'b0, sel_addr} - {1'b0, IO_BASE};
    // the >= guard keeps a wrapped subtraction from looking like a hit
    assign in_win   = (sel_addr >= IO_BASE) &&
                      (off < (ADDR_W+1)'(2 * NUM_IO));

    always_comb begin
        io_byte = 8'd0;
        io_st   = 2'd0;
        io_sel  = '0;
        for (int k = 0; k < NUM_IO; k++) begin
            if (lat_ch == CH_W'(k)) begin
                io_byte = io_rdata[8*k +: 8];
                io_st   = io_status[2*k +: 2];
                io_sel[k] = (state == ST_IO);
            end
        end
    end

    assign io_val = (lat_odd == IO_OFF_STATUS) ? DATA_W'(io_st)
                                               : DATA_W'(io_byte);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner_b   <= 1'b0;
            lat_we    <= 1'b0;
            lat_odd   <= 1'b0;
            lat_ch    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            wcnt      <= '0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (grant_a || grant_b) begin
                        owner_b   <= grant_b;
                        lat_we    <= grant_b & b_we;
                        lat_addr  <= sel_addr;
                        lat_wdata <= b_wdata;
                        lat_ch    <= off[CH_W:1];
                        lat_odd   <= off[0];
                        state     <= in_win ? ST_IO : ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    wcnt  <= CW'(WAIT_STATES - 1);
                    state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (wcnt == '0) begin
                        if (!lat_we) begin
                            if (owner_b) b_rdata <= mem_din;
                            else         a_rdata <= mem_din;
                        end
                        state <= lat_we ? ST_RECOVER : ST_DONE;
                    end else begin
                        wcnt <= wcnt - CW'(1);
                    end
                end
                ST_RECOVER: state <= ST_DONE;
                ST_IO: begin
                    if (!lat_we) begin
                        if (owner_b) b_rdata <= io_val;
                        else         a_rdata <= io_val;
                    end
                    state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign sram_act = (state == ST_SETUP) || (state == ST_ACCESS) ||
                      (state == ST_RECOVER);

    assign mem_addr  = PHYS_ADDR_W'(lat_addr);
    assign mem_dout  = lat_wdata;
    assign mem_drive = sram_act & lat_we;
    assign mem_en_n  = sram_act ? 1'b0 : STROBE_IDLE;
    assign mem_oe_n  = (state == ST_ACCESS && !lat_we) ? 1'b0 : STROBE_IDLE;
    assign mem_we_n  = (state == ST_ACCESS && lat_we) ? 1'b0 : STROBE_IDLE;

    assign io_rd    = (state == ST_IO) & ~lat_we & (lat_odd == IO_OFF_DATA);
    assign io_wr    = (state == ST_IO) & lat_we & (lat_odd == IO_OFF_DATA);
    assign io_wdata = lat_wdata[7:0];

    assign a_ack = (state == ST_DONE) & ~owner_b;
    assign b_ack = (state == ST_DONE) & owner_b;
    assign stall = (a_req & ~a_ack) | (b_req & ~b_ack);

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Scoreboarded bench: a WAIT_STATES=3 instance takes the directed traffic,
// a WAIT_STATES=1 instance covers the single-wait fetch timing.
module tb_sram_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    logic        a_req = 0, b_req = 0, b_we = 0;
    logic [15:0] a_addr = 0, b_addr = 0, b_wdata = 0;
    logic [15:0] a_rdata, b_rdata, mem_dout, mem_din;
    logic        a_ack, b_ack, stall, mem_drive;
    logic        mem_en_n, mem_oe_n, mem_we_n;
    logic [17:0] mem_addr;
    logic [1:0]  io_sel;
    logic        io_rd, io_wr;
    logic [7:0]  io_wdata;
    logic [15:0] io_rdata = 16'h5AC3;
    logic [3:0]  io_status = 4'b1001;

    logic [15:0] sram [0:262143];
    assign mem_din = sram[mem_addr];
    always @(posedge clk)
        if (!mem_en_n && !mem_we_n) sram[mem_addr] <= mem_dout;

    sram_bus_arbiter #(.WAIT_STATES(3)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_addr(a_addr), .a_rdata(a_rdata), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ack(b_ack), .stall(stall),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_drive(mem_drive),
        .mem_din(mem_din), .mem_en_n(mem_en_n), .mem_oe_n(mem_oe_n),
        .mem_we_n(mem_we_n), .io_sel(io_sel), .io_rd(io_rd), .io_wr(io_wr),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .io_status(io_status)
    );

    logic        a1_req = 0;
    logic [15:0] a1_addr = 0;
    logic [15:0] a1_rdata, b1_rdata, m1_dout, m1_din;
    logic        a1_ack, b1_ack, s1_stall, m1_drive, m1_en_n, m1_oe_n, m1_we_n;
    logic [17:0] m1_addr;
    logic [1:0]  s1_sel;
    logic        s1_rd, s1_wr;
    logic [7:0]  s1_wdata;
    assign m1_din = (m1_addr == 18'h00010) ? 16'h1234 : 16'h0000;

    sram_bus_arbiter #(.WAIT_STATES(1)) dut1 (
        .clk(clk), .rst(rst),
        .a_req(a1_req), .a_addr(a1_addr), .a_rdata(a1_rdata), .a_ack(a1_ack),
        .b_req(1'b0), .b_we(1'b0), .b_addr(16'h0), .b_wdata(16'h0),
        .b_rdata(b1_rdata), .b_ack(b1_ack), .stall(s1_stall),
        .mem_addr(m1_addr), .mem_dout(m1_dout), .mem_drive(m1_drive),
        .mem_din(m1_din), .mem_en_n(m1_en_n), .mem_oe_n(m1_oe_n),
        .mem_we_n(m1_we_n), .io_sel(s1_sel), .io_rd(s1_rd), .io_wr(s1_wr),
        .io_wdata(s1_wdata), .io_rdata(16'h0), .io_status(4'h0)
    );

    typedef struct {
        int          id;
        logic        is_b;
        logic        chk_data;
        logic [15:0] data;
        int          exp_cyc;
        int          oe, we, drv, iord, iowr;
        logic [1:0]  sel;
        logic [7:0]  wd;
    } item_t;

    item_t q[$];

    task automatic chk(input string nm, input int id,
                       input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s[%0d] actual=%0h required=%0h", nm, id, act, req);
        end
    endtask

    function automatic item_t mk(input int id, input logic isb, input logic wr,
                                 input logic [15:0] d, input int ec,
                                 input int oe, input int we, input int drv,
                                 input int rd, input int wrs,
                                 input logic [1:0] sel, input logic [7:0] wd);
        item_t it;
        it.id = id; it.is_b = isb; it.chk_data = ~wr; it.data = d;
        it.exp_cyc = ec; it.oe = oe; it.we = we; it.drv = drv;
        it.iord = rd; it.iowr = wrs; it.sel = sel; it.wd = wd;
        return it;
    endfunction

    int n_oe = 0, n_we = 0, n_drv = 0, n_rd = 0, n_wr = 0;
    logic [1:0] acc_sel = 0;
    logic [7:0] acc_wd = 0;

    always @(negedge clk) begin
        item_t it;
        if (rst) begin
            n_oe = 0; n_we = 0; n_drv = 0; n_rd = 0; n_wr = 0;
            acc_sel = 0; acc_wd = 0;
        end else if (a_ack || b_ack) begin
            if (a_ack && b_ack) chk("dual_ack", -1, 1, 0);
            if (q.size() == 0) begin
                chk("unexpected_ack", -1, {a_ack, b_ack}, 0);
            end else begin
                it = q.pop_front();
                chk("port", it.id, b_ack, it.is_b);
                if (it.chk_data)
                    chk("rdata", it.id, b_ack ? b_rdata : a_rdata, it.data);
                if (it.exp_cyc >= 0) chk("ack_cycle", it.id, cyc, it.exp_cyc);
                chk("oe_cycles", it.id, n_oe, it.oe);
                chk("we_cycles", it.id, n_we, it.we);
                chk("drive_cycles", it.id, n_drv, it.drv);
                chk("io_rd_pulses", it.id, n_rd, it.iord);
                chk("io_wr_pulses", it.id, n_wr, it.iowr);
                chk("io_sel", it.id, acc_sel, it.sel);
                chk("io_wdata", it.id, acc_wd, it.wd);
            end
            n_oe = 0; n_we = 0; n_drv = 0; n_rd = 0; n_wr = 0;
            acc_sel = 0; acc_wd = 0;
        end else begin
            if (!mem_oe_n) n_oe++;
            if (!mem_we_n) n_we++;
            if (mem_drive) n_drv++;
            if (io_rd) n_rd++;
            if (io_wr) begin n_wr++; acc_wd |= io_wdata; end
            acc_sel |= io_sel;
        end
    end

    task automatic wait_ack(input int id, input logic isb);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(isb ? b_ack : a_ack) && n < 40);
        if (!(isb ? b_ack : a_ack)) chk("ack_timeout", id, 0, 1);
    endtask

    task automatic txn(input int id, input logic isb, input logic wr,
                       input logic [15:0] addr, input logic [15:0] wd,
                       input logic [15:0] d, input int lat,
                       input int oe, input int we, input int drv,
                       input int rd, input int wrs,
                       input logic [1:0] sel, input logic [7:0] iowd);
        @(posedge clk); #1;
        if (isb) begin
            b_req = 1; b_we = wr; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = 1; a_addr = addr;
        end
        q.push_back(mk(id, isb, wr, d, cyc + lat, oe, we, drv, rd, wrs,
                       sel, iowd));
        wait_ack(id, isb);
        @(posedge clk); #1;
        a_req = 0; b_req = 0; b_we = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, n, oe_cnt, acks;
        sram[18'h00100] = 16'hAAAA;
        sram[18'h00200] = 16'hBBBB;
        sram[18'h0BF04] = 16'h7777;
        sram[18'h0BEFF] = 16'h3333;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ack", 0, a_ack, 0);
        chk("rst_b_ack", 0, b_ack, 0);
        chk("rst_strobes", 0, {mem_en_n, mem_oe_n, mem_we_n}, 3'b111);
        chk("rst_drive", 0, mem_drive, 0);
        chk("rst_io", 0, {io_sel, io_rd, io_wr}, 0);
        chk("rst_rdata", 0, {a_rdata, b_rdata}, 0);
        chk("rst_stall", 0, stall, 0);
        chk("rst_dut1_oe", 0, m1_oe_n, 1);
        @(posedge clk); #1;
        rst = 0;

        // single-wait fetch on the second instance
        @(posedge clk); #1;
        a1_req = 1; a1_addr = 16'h0010; t = cyc; n = 0; oe_cnt = 0;
        do begin
            @(negedge clk);
            n++;
            if (!m1_oe_n) oe_cnt++;
        end while (!a1_ack && n < 40);
        chk("w1_ack_seen", 1, a1_ack, 1);
        chk("w1_ack_cycle", 1, cyc, t + 3);
        chk("w1_rdata", 1, a1_rdata, 16'h1234);
        chk("w1_oe_cycles", 1, oe_cnt, 1);
        @(posedge clk); #1;
        a1_req = 0;

        txn(2, 1, 1, 16'h0020, 16'hBEEF, 0, 6, 0, 3, 5, 0, 0, 2'b00, 8'h00);
        txn(3, 0, 0, 16'h0020, 0, 16'hBEEF, 5, 3, 0, 0, 0, 0, 2'b00, 8'h00);
        txn(4, 1, 0, 16'hBF03, 0, 16'h0002, 2, 0, 0, 0, 0, 0, 2'b10, 8'h00);
        txn(5, 1, 1, 16'hBF02, 16'h0041, 0, 2, 0, 0, 0, 0, 1, 2'b10, 8'h41);
        txn(6, 1, 0, 16'hBF00, 0, 16'h00C3, 2, 0, 0, 0, 1, 0, 2'b01, 8'h00);
        txn(7, 0, 0, 16'hBF01, 0, 16'h0001, 2, 0, 0, 0, 0, 0, 2'b01, 8'h00);
        txn(8, 0, 0, 16'hBF04, 0, 16'h7777, 5, 3, 0, 0, 0, 0, 2'b00, 8'h00);
        txn(9, 1, 0, 16'hBEFF, 0, 16'h3333, 5, 3, 0, 0, 0, 0, 2'b00, 8'h00);
        txn(10, 1, 1, 16'hBF01, 16'h0055, 0, 2, 0, 0, 0, 0, 0, 2'b01, 8'h00);

        // both ports held: expect B,B,A,B,B,A
        for (int i = 0; i < 6; i++) begin
            logic isb;
            isb = (i % 3) != 2;
            q.push_back(mk(20 + i, isb, 0, isb ? 16'hBBBB : 16'hAAAA, -1,
                           3, 0, 0, 0, 0, 2'b00, 8'h00));
        end
        @(posedge clk); #1;
        a_req = 1; a_addr = 16'h0100;
        b_req = 1; b_we = 0; b_addr = 16'h0200;
        acks = 0; n = 0;
        while (acks < 6 && n < 200) begin
            @(negedge clk);
            n++;
            if (a_ack || b_ack) acks++;
        end
        chk("arb_acks", 20, acks, 6);
        @(posedge clk); #1;
        a_req = 0; b_req = 0;
        @(negedge clk);
        chk("arb_queue_empty", 20, q.size(), 0);

        // reset in the middle of a write access
        @(posedge clk); #1;
        b_req = 1; b_we = 1; b_addr = 16'h0030; b_wdata = 16'h1111;
        repeat (2) @(posedge clk);
        #1;
        rst = 1; b_req = 0; b_we = 0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_strobes", 30, {mem_en_n, mem_we_n}, 2'b11);
        chk("abort_drive", 30, mem_drive, 0);
        chk("abort_b_ack", 30, b_ack, 0);
        chk("abort_rdata", 30, {a_rdata, b_rdata}, 0);
        @(posedge clk); #1;
        rst = 0;
        repeat (8) @(negedge clk);

        // request withdrawn after grant still completes once
        @(posedge clk); #1;
        b_req = 1; b_we = 0; b_addr = 16'h0200;
        q.push_back(mk(40, 1, 0, 16'hBBBB, cyc + 5, 3, 0, 0, 0, 0,
                       2'b00, 8'h00));
        @(posedge clk); #1;
        b_req = 0;
        wait_ack(40, 1);
        @(negedge clk);
        chk("drop_stall", 40, stall, 0);
        repeat (6) @(negedge clk);
        chk("drop_stall_late", 40, stall, 0);
        chk("final_queue_empty", 41, q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
